// File: rtl/instr_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : instr_seq_pkg
// Purpose  : Shared constants, state classes and helpers for instr_seq.
//            Holds the legal MAX_EXEC range, the positions of each phase
//            inside the one-hot state vector, and the NEXEC clamp function.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_seq_pkg;

   // Legal range for the number of execute phases
   localparam int MAX_EXEC_MIN = 2;
   localparam int MAX_EXEC_MAX = 8;

   // Bit positions inside the one-hot state vector:
   //   bit 0              : FETCH
   //   bits 1..MAX_EXEC   : EXEC1..EXEC<MAX_EXEC>
   //   bit MAX_EXEC+1     : HALTED (only present when the halt feature is built)
   localparam int IDX_FETCH = 0;
   localparam int IDX_EXEC1 = 1;

   function automatic int idx_halted(input int max_exec);
      return max_exec + 1;
   endfunction

   // Decoded class of the current state vector
   typedef enum logic [1:0] {
      CLS_FETCH   = 2'd0,
      CLS_EXEC    = 2'd1,
      CLS_HALTED  = 2'd2,
      CLS_ILLEGAL = 2'd3
   } state_class_t;

   // Execute-phase count of an instruction: 0 means a single phase, anything
   // above the supported depth saturates at the deepest phase.
   function automatic int nexec_clamp(input int raw, input int max_exec);
      if (raw == 0) begin
         return 1;
      end
      if (raw > max_exec) begin
         return max_exec;
      end
      return raw;
   endfunction

endpackage : instr_seq_pkg

`default_nettype wire

// File: rtl/instr_seq.sv
//------------------------------------------------------------------------------
// Module   : instr_seq
// Purpose  : Instruction phase sequencer. Steps FETCH -> EXEC1 -> ... -> EXECn
//            -> FETCH, where n is the instruction's execute-phase count taken
//            from NEXEC while leaving EXEC1. STALL freezes all state.
// Config   : SEQ_HALT_EN - when defined, adds a HALTED state entered from the
//            final execute cycle when HALT=1, left on the first edge with
//            HALT=0. When undefined, HALT is ignored.
// Ports    :
//   CLK    in   1         clock, rising edge
//   RST    in   1         asynchronous active-high reset
//   STALL  in   1         hold current phase this cycle
//   NEXEC  in   CW        execute-phase count (used in EXEC1)
//   HALT   in   1         stop after current instruction (SEQ_HALT_EN only)
//   FETCH  out  1         fetch phase active
//   EXEC   out  MAX_EXEC  one-hot execute phase, bit k-1 = EXECk
//   PHASE  out  CW        0 in FETCH/HALTED, k in EXECk
//   DONE   out  1         final execute cycle completing this cycle
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_seq
   import instr_seq_pkg::*;
#(
   parameter int MAX_EXEC = 4,
   parameter int CW       = $clog2(MAX_EXEC + 1)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                STALL,
   input  logic [CW-1:0]       NEXEC,
   input  logic                HALT,
   output logic                FETCH,
   output logic [MAX_EXEC-1:0] EXEC,
   output logic [CW-1:0]       PHASE,
   output logic                DONE
);

   if (MAX_EXEC < MAX_EXEC_MIN || MAX_EXEC > MAX_EXEC_MAX) begin : g_bad_max_exec
      $error("instr_seq: MAX_EXEC outside supported range");
   end

`ifdef SEQ_HALT_EN
   localparam int HALT_IDX = idx_halted(MAX_EXEC);
   localparam int SW       = MAX_EXEC + 2;
`else
   localparam int SW       = MAX_EXEC + 1;
`endif

   localparam logic [SW-1:0] FETCH_VEC = SW'(1) << IDX_FETCH;
   localparam logic [SW-1:0] EXEC1_VEC = SW'(1) << IDX_EXEC1;
`ifdef SEQ_HALT_EN
   localparam logic [SW-1:0] HALT_VEC  = SW'(1) << HALT_IDX;
`endif

   logic [SW-1:0]  state_q, next_state;
   logic [CW-1:0]  phase_q, next_phase;
   logic [CW-1:0]  n_q, next_n;
   state_class_t   cls;
   logic [CW-1:0]  cur_k;
   logic [CW-1:0]  nexec_clamped;
   logic [CW-1:0]  n_eff;
   logic           last_exec;

`ifndef SEQ_HALT_EN
   logic unused_halt;
   assign unused_halt = HALT;
`endif

   //---------------------------------------------------------------------------
   // State, phase and latched count registers
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FETCH_VEC;
         phase_q <= '0;
         n_q     <= CW'(1);
      end else begin
         state_q <= next_state;
         phase_q <= next_phase;
         n_q     <= next_n;
      end
   end

   //---------------------------------------------------------------------------
   // Decode current state
   //---------------------------------------------------------------------------
   always_comb begin
      cls   = CLS_ILLEGAL;
      cur_k = '0;
      if (!$onehot(state_q)) begin
         cls = CLS_ILLEGAL;
      end else if (state_q[IDX_FETCH]) begin
         cls = CLS_FETCH;
`ifdef SEQ_HALT_EN
      end else if (state_q[HALT_IDX]) begin
         cls = CLS_HALTED;
`endif
      end else begin
         cls = CLS_EXEC;
         for (int k = 1; k <= MAX_EXEC; k++) begin
            if (state_q[k]) begin
               cur_k = CW'(k);
            end
         end
      end
   end

   assign nexec_clamped = CW'(nexec_clamp(int'(NEXEC), MAX_EXEC));

   // In EXEC1 the count is still live on NEXEC; later phases use the latch.
   assign n_eff     = state_q[IDX_EXEC1] ? nexec_clamped : n_q;
   assign last_exec = (cls == CLS_EXEC) && (cur_k >= n_eff);

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      next_state = state_q;
      next_phase = phase_q;
      next_n     = n_q;
      case (cls)
         CLS_FETCH: begin
            if (!STALL) begin
               next_state = EXEC1_VEC;
               next_phase = CW'(1);
            end
         end
         CLS_EXEC: begin
            if (!STALL) begin
               if (state_q[IDX_EXEC1]) begin
                  next_n = nexec_clamped;
               end
               if (!last_exec) begin
                  // k < n <= MAX_EXEC, so the shift stays inside the EXEC field
                  next_state = state_q << 1;
                  next_phase = cur_k + CW'(1);
               end else begin
                  next_state = FETCH_VEC;
                  next_phase = '0;
`ifdef SEQ_HALT_EN
                  if (HALT) begin
                     next_state = HALT_VEC;
                  end
`endif
               end
            end
         end
`ifdef SEQ_HALT_EN
         CLS_HALTED: begin
            if (!STALL && !HALT) begin
               next_state = FETCH_VEC;
               next_phase = '0;
            end
         end
`endif
         default: begin
            // Corrupted state vector: recover to FETCH regardless of STALL
            next_state = FETCH_VEC;
            next_phase = '0;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign FETCH = state_q[IDX_FETCH];
   assign EXEC  = state_q[MAX_EXEC:IDX_EXEC1];
   assign PHASE = phase_q;
   assign DONE  = last_exec && !STALL;

endmodule : instr_seq

`default_nettype wire

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have parameter MAX_EXEC, default 4, number of execute phases supported (legal 2..8).
REQ-002 SHALL have parameter CW, default $clog2(MAX_EXEC+1), width of NEXEC and PHASE.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port STALL  input  1  hold current phase for this cycle.
REQ-006 SHALL have port NEXEC  input  CW  execute-phase count of current instruction, sampled in EXEC1.
REQ-007 SHALL have port HALT  input  1  stop after current instruction (used only with SEQ_HALT_EN).
REQ-008 SHALL have port FETCH  output  1  fetch phase active.
REQ-009 SHALL have port EXEC  output  MAX_EXEC  one-hot execute phase; bit k-1 = EXECk.
REQ-010 SHALL have port PHASE  output  CW  0 in FETCH, k in EXECk, 0 in HALTED.
REQ-011 SHALL have port DONE  output  1  final execute cycle of an instruction completing this cycle.

Function
REQ-012 SHALL hold state as a registered one-hot vector {HALTED, EXEC[MAX_EXEC], FETCH}; FETCH/EXEC outputs driven directly from state flops.
REQ-013 SHALL move FETCH -> EXEC1 on each edge where STALL=0.
REQ-014 SHALL, on leaving EXEC1, latch n = NEXEC, with 0 treated as 1 and values > MAX_EXEC clamped to MAX_EXEC.
REQ-015 SHALL move EXECk -> EXEC(k+1) when k < n, and EXECn -> FETCH, each only when STALL=0.
REQ-016 SHALL, while in EXEC1, use the NEXEC value present on the non-stalled leaving cycle (stalled-cycle samples discarded).
REQ-017 SHALL hold state, PHASE and latched n unchanged on any edge with STALL=1.
REQ-018 SHALL assert DONE combinationally when in EXECn (n taken from NEXEC-clamp while in EXEC1) and STALL=0.
REQ-019 SHALL force FETCH on the next edge if the state vector is ever not one-hot.
REQ-020 SHALL give exactly one of FETCH/EXEC/HALTED high in every cycle.

Reset
REQ-021 SHALL, on RST=1, immediately set FETCH=1, EXEC=0, PHASE=0, latched n=1, DONE=0, independent of CLK.
REQ-022 SHALL abandon any in-progress instruction when RST asserts mid-operation; first edge after release with STALL=0 goes to EXEC1.

Configuration
REQ-023 SHALL compile HALTED state in only when SEQ_HALT_EN is defined.
REQ-024 With SEQ_HALT_EN: DONE cycle with HALT=1 goes to HALTED instead of FETCH; HALTED -> FETCH on first edge with HALT=0; STALL has priority over HALT.
REQ-025 Without SEQ_HALT_EN: HALT ignored, HALTED flop absent, EXECn always -> FETCH.

Structure
REQ-026 SHALL place MAX_EXEC bounds, one-hot state index constants and the NEXEC clamp function in shared package instr_seq_pkg.
REQ-027 SHALL be a single module; no sub-module required.

Verification
REQ-028 MAX_EXEC=4, NEXEC=2, STALL=0 -> FETCH,EXEC1,EXEC2(DONE),FETCH repeating, period 3.
REQ-029 NEXEC=0 then NEXEC=7 -> FETCH,EXEC1(DONE),FETCH; then EXEC1..EXEC4, DONE only in EXEC4.
REQ-030 NEXEC=3, STALL=1 for 2 cycles in EXEC2 -> EXEC2 held 3 cycles, PHASE=2, DONE only in EXEC3.
REQ-031 NEXEC=1 in stalled EXEC1 cycle, 3 on leaving cycle -> sequence runs to EXEC3.
REQ-032 RST pulsed mid-EXEC3 between edges -> FETCH=1, EXEC=0 before next edge.
REQ-033 SEQ_HALT_EN, HALT=1 at DONE -> all outputs 0, PHASE=0; HALT=0 -> FETCH next edge.
